// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results, suppresses misaligned
// memory accesses into a sticky exception record and counts committed memory operations.
module ex_mem_register #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_flush,
    input  logic                i_clr_exc,
    input  logic                i_valid,
    input  logic [NBITS-1:0]    i_eff_addr,
    input  logic [NBITS-1:0]    i_store_data,
    input  logic [1:0]          i_flg_mem_size,
    input  logic                i_flg_unsign,
    input  logic                i_flg_mem_type,
    input  logic                i_flg_mem_read,
    input  logic                i_flg_reg_wr,
    input  logic [4:0]          i_reg_dst,
    input  logic [NBITS-1:0]    i_pc,
    output logic                o_valid,
    output logic [NBITS-1:0]    o_eff_addr,
    output logic [NBITS-1:0]    o_store_data,
    output logic [1:0]          o_flg_mem_size,
    output logic                o_flg_unsign,
    output logic                o_flg_mem_type,
    output logic                o_flg_mem_read,
    output logic                o_flg_reg_wr,
    output logic [4:0]          o_reg_dst,
    output logic [NBITS-1:0]    o_pc,
    output logic                o_flg_misaligned,
    output logic [NBITS-1:0]    o_bad_addr,
    output logic [NBITS-1:0]    o_bad_pc,
    output logic [CNT_BITS-1:0] o_mem_ops
);

    logic                w_access;
    logic                w_misaligned;
    logic                w_capture;
    logic                w_keep;

    logic                r_valid;
    logic [NBITS-1:0]    r_eff_addr;
    logic [NBITS-1:0]    r_store_data;
    logic [1:0]          r_flg_mem_size;
    logic                r_flg_unsign;
    logic                r_flg_mem_type;
    logic                r_flg_mem_read;
    logic                r_flg_reg_wr;
    logic [4:0]          r_reg_dst;
    logic [NBITS-1:0]    r_pc;
    logic                r_flg_misaligned;
    logic [NBITS-1:0]    r_bad_addr;
    logic [NBITS-1:0]    r_bad_pc;
    logic [CNT_BITS-1:0] r_mem_ops;

    assign w_access  = i_valid & (i_flg_mem_type | i_flg_mem_read);
    assign w_capture = i_en & ~i_flush;

    always_comb begin
        w_misaligned = 1'b0;
        if (w_access) begin
            case (i_flg_mem_size)
                2'b00:   w_misaligned = 1'b0;
                2'b01:   w_misaligned = i_eff_addr[0];
                default: w_misaligned = (i_eff_addr[1:0] != 2'b00);
            endcase
        end
    end

    // Memory and write-back side effects survive only for a real, aligned instruction.
    assign w_keep = i_valid & ~w_misaligned;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid          <= 1'b0;
            r_eff_addr       <= '0;
            r_store_data     <= '0;
            r_flg_mem_size   <= 2'b00;
            r_flg_unsign     <= 1'b0;
            r_flg_mem_type   <= 1'b0;
            r_flg_mem_read   <= 1'b0;
            r_flg_reg_wr     <= 1'b0;
            r_reg_dst        <= 5'd0;
            r_pc             <= '0;
            r_flg_misaligned <= 1'b0;
            r_bad_addr       <= '0;
            r_bad_pc         <= '0;
            r_mem_ops        <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_valid        <= 1'b0;
                r_eff_addr     <= '0;
                r_store_data   <= '0;
                r_flg_mem_size <= 2'b00;
                r_flg_unsign   <= 1'b0;
                r_flg_mem_type <= 1'b0;
                r_flg_mem_read <= 1'b0;
                r_flg_reg_wr   <= 1'b0;
                r_reg_dst      <= 5'd0;
                r_pc           <= '0;
            end else begin
                r_valid        <= i_valid;
                r_eff_addr     <= i_eff_addr;
                r_store_data   <= i_store_data;
                r_flg_mem_size <= i_valid ? i_flg_mem_size : 2'b00;
                r_flg_unsign   <= i_valid & i_flg_unsign;
                r_flg_mem_type <= w_keep & i_flg_mem_type;
                r_flg_mem_read <= w_keep & i_flg_mem_read;
                r_flg_reg_wr   <= w_keep & i_flg_reg_wr;
                r_reg_dst      <= i_reg_dst;
                r_pc           <= i_pc;
            end

            // A new fault beats a clear in the same cycle; otherwise the first fault is kept.
            if (w_capture && w_misaligned && (!r_flg_misaligned || i_clr_exc)) begin
                r_flg_misaligned <= 1'b1;
                r_bad_addr       <= i_eff_addr;
                r_bad_pc         <= i_pc;
            end else if (i_clr_exc) begin
                r_flg_misaligned <= 1'b0;
                r_bad_addr       <= '0;
                r_bad_pc         <= '0;
            end

            if (w_capture && w_access && !w_misaligned && (r_mem_ops != {CNT_BITS{1'b1}})) begin
                r_mem_ops <= r_mem_ops + 1'b1;
            end
        end
    end

    assign o_valid          = r_valid;
    assign o_eff_addr       = r_eff_addr;
    assign o_store_data     = r_store_data;
    assign o_flg_mem_size   = r_flg_mem_size;
    assign o_flg_unsign     = r_flg_unsign;
    assign o_flg_mem_type   = r_flg_mem_type;
    assign o_flg_mem_read   = r_flg_mem_read;
    assign o_flg_reg_wr     = r_flg_reg_wr;
    assign o_reg_dst        = r_reg_dst;
    assign o_pc             = r_pc;
    assign o_flg_misaligned = r_flg_misaligned;
    assign o_bad_addr       = r_bad_addr;
    assign o_bad_pc         = r_bad_pc;
    assign o_mem_ops        = r_mem_ops;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register with a 4-bit counter so saturation is reachable.
module tb_ex_mem_register;

    localparam int NBITS    = 32;
    localparam int CNT_BITS = 4;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_en;
    logic                i_flush;
    logic                i_clr_exc;
    logic                i_valid;
    logic [NBITS-1:0]    i_eff_addr;
    logic [NBITS-1:0]    i_store_data;
    logic [1:0]          i_flg_mem_size;
    logic                i_flg_unsign;
    logic                i_flg_mem_type;
    logic                i_flg_mem_read;
    logic                i_flg_reg_wr;
    logic [4:0]          i_reg_dst;
    logic [NBITS-1:0]    i_pc;
    logic                o_valid;
    logic [NBITS-1:0]    o_eff_addr;
    logic [NBITS-1:0]    o_store_data;
    logic [1:0]          o_flg_mem_size;
    logic                o_flg_unsign;
    logic                o_flg_mem_type;
    logic                o_flg_mem_read;
    logic                o_flg_reg_wr;
    logic [4:0]          o_reg_dst;
    logic [NBITS-1:0]    o_pc;
    logic                o_flg_misaligned;
    logic [NBITS-1:0]    o_bad_addr;
    logic [NBITS-1:0]    o_bad_pc;
    logic [CNT_BITS-1:0] o_mem_ops;

    int checks = 0;
    int errors = 0;

    ex_mem_register #(.NBITS(NBITS), .CNT_BITS(CNT_BITS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
        .i_clr_exc(i_clr_exc), .i_valid(i_valid), .i_eff_addr(i_eff_addr),
        .i_store_data(i_store_data), .i_flg_mem_size(i_flg_mem_size),
        .i_flg_unsign(i_flg_unsign), .i_flg_mem_type(i_flg_mem_type),
        .i_flg_mem_read(i_flg_mem_read), .i_flg_reg_wr(i_flg_reg_wr),
        .i_reg_dst(i_reg_dst), .i_pc(i_pc), .o_valid(o_valid),
        .o_eff_addr(o_eff_addr), .o_store_data(o_store_data),
        .o_flg_mem_size(o_flg_mem_size), .o_flg_unsign(o_flg_unsign),
        .o_flg_mem_type(o_flg_mem_type), .o_flg_mem_read(o_flg_mem_read),
        .o_flg_reg_wr(o_flg_reg_wr), .o_reg_dst(o_reg_dst), .o_pc(o_pc),
        .o_flg_misaligned(o_flg_misaligned), .o_bad_addr(o_bad_addr),
        .o_bad_pc(o_bad_pc), .o_mem_ops(o_mem_ops)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input logic unsign, input logic st,
                         input logic ld, input logic rw, input logic [4:0] dst,
                         input logic [31:0] pc);
        i_valid        = valid;
        i_eff_addr     = addr;
        i_store_data   = data;
        i_flg_mem_size = size;
        i_flg_unsign   = unsign;
        i_flg_mem_type = st;
        i_flg_mem_read = ld;
        i_flg_reg_wr   = rw;
        i_reg_dst      = dst;
        i_pc           = pc;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_ops;
        i_rst     = 1'b0;
        i_en      = 1'b1;
        i_flush   = 1'b0;
        i_clr_exc = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Reset held with random stimulus
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, 1'b1,
                  5'($urandom_range(0, 31)), $urandom);
            i_clr_exc = 1'($urandom_range(0, 1));
            step();
        end
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_addr", o_eff_addr, 32'h0);
        chk("rst_data", o_store_data, 32'h0);
        chk("rst_flags", {26'h0, o_flg_mem_size, o_flg_unsign, o_flg_mem_type, o_flg_mem_read, o_flg_reg_wr}, 32'h0);
        chk("rst_dst_pc", o_pc | 32'(o_reg_dst), 32'h0);
        chk("rst_exc", o_bad_addr | o_bad_pc | 32'(o_flg_misaligned), 32'h0);
        chk("rst_ops", 32'(o_mem_ops), 32'h0);

        #2 i_rst = 1'b1;
        i_clr_exc = 1'b0;
        drive(1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h40);
        step();
        chk("ld_valid", 32'(o_valid), 32'h1);
        chk("ld_addr", o_eff_addr, 32'h10);
        chk("ld_read", 32'(o_flg_mem_read), 32'h1);
        chk("ld_regwr", 32'(o_flg_reg_wr), 32'h1);
        chk("ld_pc", o_pc, 32'h40);
        chk("ld_ops", 32'(o_mem_ops), 32'h1);

        // Store, then stall with changing inputs and an ignored flush
        drive(1'b1, 32'h20, 32'hDEADBEEF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h44);
        step();
        chk("st_type", 32'(o_flg_mem_type), 32'h1);
        chk("st_ops", 32'(o_mem_ops), 32'h2);
        i_en    = 1'b0;
        i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'h55 + 32'(i), 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h200);
            step();
        end
        chk("stall_addr", o_eff_addr, 32'h20);
        chk("stall_data", o_store_data, 32'hDEADBEEF);
        chk("stall_type", 32'(o_flg_mem_type), 32'h1);
        chk("stall_ops", 32'(o_mem_ops), 32'h2);

        i_en = 1'b1;
        step();
        chk("flush_valid", 32'(o_valid), 32'h0);
        chk("flush_flags", {28'h0, o_flg_mem_type, o_flg_mem_read, o_flg_reg_wr, o_flg_unsign}, 32'h0);
        chk("flush_addr", o_eff_addr, 32'h0);
        chk("flush_ops", 32'(o_mem_ops), 32'h2);
        i_flush = 1'b0;

        // Misalignment and first-fault-wins
        drive(1'b1, 32'h21, 32'h1234, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80);
        step();
        chk("mis_h_valid", 32'(o_valid), 32'h1);
        chk("mis_h_type", 32'(o_flg_mem_type), 32'h0);
        chk("mis_h_flag", 32'(o_flg_misaligned), 32'h1);
        chk("mis_h_bad_addr", o_bad_addr, 32'h21);
        chk("mis_h_bad_pc", o_bad_pc, 32'h80);
        chk("mis_h_ops", 32'(o_mem_ops), 32'h2);

        drive(1'b1, 32'h22, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h84);
        step();
        chk("mis_w_read", 32'(o_flg_mem_read), 32'h0);
        chk("mis_w_regwr", 32'(o_flg_reg_wr), 32'h0);
        chk("mis_w_bad_addr", o_bad_addr, 32'h21);
        chk("mis_w_bad_pc", o_bad_pc, 32'h80);

        drive(1'b1, 32'h23, 32'hAB, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h88);
        step();
        chk("byte_type", 32'(o_flg_mem_type), 32'h1);
        chk("byte_ops", 32'(o_mem_ops), 32'h3);
        chk("byte_flag", 32'(o_flg_misaligned), 32'h1);

        // Non-memory op and invalid slot: no counting, masked flags
        drive(1'b1, 32'h33, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h8C);
        step();
        chk("alu_regwr", 32'(o_flg_reg_wr), 32'h1);
        chk("alu_ops", 32'(o_mem_ops), 32'h3);
        chk("alu_bad_addr", o_bad_addr, 32'h21);
        drive(1'b0, 32'h40, 32'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h8C);
        step();
        chk("inv_valid", 32'(o_valid), 32'h0);
        chk("inv_flags", {26'h0, o_flg_mem_size, o_flg_unsign, o_flg_mem_type, o_flg_mem_read, o_flg_reg_wr}, 32'h0);
        chk("inv_ops", 32'(o_mem_ops), 32'h3);

        // Clear alone, then clear together with a new fault
        i_clr_exc = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("clr_flag", 32'(o_flg_misaligned), 32'h0);
        chk("clr_bad", o_bad_addr | o_bad_pc, 32'h0);
        drive(1'b1, 32'h31, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h90);
        step();
        chk("clrset_flag", 32'(o_flg_misaligned), 32'h1);
        chk("clrset_bad_addr", o_bad_addr, 32'h31);
        chk("clrset_bad_pc", o_bad_pc, 32'h90);
        chk("clrset_read", 32'(o_flg_mem_read), 32'h0);
        i_clr_exc = 1'b0;

        // Counter saturation: 3 already counted, limit 15
        exp_ops = 4'd3;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h100 + 32'(i * 4));
            step();
            if (exp_ops != 4'hF) exp_ops = exp_ops + 4'd1;
            chk($sformatf("sat_ops_%0d", i), 32'(o_mem_ops), 32'(exp_ops));
        end
        drive(1'b1, 32'h77, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h300);
        step();
        chk("sat_alu_ops", 32'(o_mem_ops), 32'hF);

        // Fault, then asynchronous reset between edges
        drive(1'b1, 32'h41, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h304);
        step();
        chk("pre_arst_flag", 32'(o_flg_misaligned), 32'h1);
        chk("pre_arst_valid", 32'(o_valid), 32'h1);
        #2 i_rst = 1'b0;
        #1;
        chk("arst_flag", 32'(o_flg_misaligned), 32'h0);
        chk("arst_bad", o_bad_addr | o_bad_pc, 32'h0);
        chk("arst_valid", 32'(o_valid), 32'h0);
        chk("arst_addr_pc", o_eff_addr | o_pc, 32'h0);
        chk("arst_ops", 32'(o_mem_ops), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
